// File: rtl/fpu_op_scheduler.sv
// fpu_op_scheduler
// Shares a single adder / multiplier / divider set between NUM_REQ requesters.
// One operation is in flight at a time: round-robin grant, operand latch,
// one-cycle start strobe to the selected unit, fixed-latency wait, result
// capture, and a tagged response with valid/ready backpressure.
// Optional build macro: FPU_SCHED_STATS_EN adds the stat_ops / stat_errs
// counters and their output ports.
module fpu_op_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ADD_LAT = 12,
  parameter int MUL_LAT = 12,
  parameter int DIV_LAT = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [2*NUM_REQ-1:0]   req_op,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [2:0]             resp_id,
  output logic [31:0]            resp_data,
  output logic                   resp_err,
  output logic [31:0]            fpu_a,
  output logic [31:0]            fpu_b,
  output logic                   add_valid,
  output logic                   mul_valid,
  output logic                   div_valid,
  input  logic [31:0]            add_sum,
  input  logic [31:0]            mul_res,
  input  logic [31:0]            div_res,
  input  logic                   add_err,
  input  logic                   mul_err,
  input  logic                   div_err
`ifdef FPU_SCHED_STATS_EN
  ,
  output logic [31:0]            stat_ops,
  output logic [15:0]            stat_errs
`endif
);

  localparam logic [1:0]  OP_ADD     = 2'b00;
  localparam logic [1:0]  OP_SUB     = 2'b01;
  localparam logic [1:0]  OP_MUL     = 2'b10;
  localparam logic [1:0]  OP_DIV     = 2'b11;
  localparam logic [2:0]  LAST_IDX   = 3'(NUM_REQ - 1);
  localparam logic [3:0]  NUM_REQ_W  = 4'(NUM_REQ);
  localparam logic [15:0] ADD_RELOAD = 16'(ADD_LAT - 1);
  localparam logic [15:0] MUL_RELOAD = 16'(MUL_LAT - 1);
  localparam logic [15:0] DIV_RELOAD = 16'(DIV_LAT - 1);
  localparam logic [NUM_REQ-1:0] REQ_ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t               state_r;
  state_t               state_nx_s;
  logic [2:0]           rr_ptr_r;
  logic [1:0]           op_r;
  logic [2:0]           id_r;
  logic [15:0]          cnt_r;
  logic [15:0]          reload_s;
  logic [2*NUM_REQ-1:0] req_dbl_s;
  logic [2*NUM_REQ-1:0] req_rot_s;
  logic                 grant_any_s;
  logic [2:0]           grant_off_s;
  logic [3:0]           grant_sum_s;
  logic [2:0]           grant_idx_s;
  logic                 accept_s;
  logic [1:0]           sel_op_s;
  logic [31:0]          sel_a_s;
  logic [31:0]          sel_b_s;
  logic [31:0]          unit_data_s;
  logic                 unit_err_s;
  logic                 sample_s;
  logic                 handshake_s;

  // Round-robin search: rotate requests so rr_ptr sits at bit 0, take the lowest set bit
  always_comb begin
    req_dbl_s   = {req_valid, req_valid};
    req_rot_s   = req_dbl_s >> rr_ptr_r;
    grant_any_s = 1'b0;
    grant_off_s = 3'd0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      grant_any_s = grant_any_s | 1'(req_rot_s >> k);
      grant_off_s = 1'(req_rot_s >> k) ? 3'(k) : grant_off_s;
    end
    grant_sum_s = {1'b0, rr_ptr_r} + {1'b0, grant_off_s};
    if (grant_sum_s >= NUM_REQ_W) begin
      grant_idx_s = 3'(grant_sum_s - NUM_REQ_W);
    end else begin
      grant_idx_s = grant_sum_s[2:0];
    end
  end

  assign accept_s    = (state_r == ST_IDLE) && grant_any_s;
  assign sample_s    = (state_r == ST_WAIT) && (cnt_r == 16'd0);
  assign handshake_s = (state_r == ST_RESP) && resp_valid && resp_ready;

  // Operand and opcode of the granted requester
  always_comb begin
    sel_op_s = 2'(req_op >> {grant_idx_s, 1'b0});
    sel_a_s  = 32'(req_a >> {grant_idx_s, 5'd0});
    sel_b_s  = 32'(req_b >> {grant_idx_s, 5'd0});
  end

  // One-hot accept, only while idle and never while reset is asserted
  always_comb begin
    req_ready = {NUM_REQ{1'b0}};
    if (accept_s && !rst) begin
      req_ready = REQ_ONE << grant_idx_s;
    end else begin
      req_ready = {NUM_REQ{1'b0}};
    end
  end

  // Wait reload value and result/error mux for the unit owning the op
  always_comb begin
    reload_s    = 16'd0;
    unit_data_s = 32'd0;
    unit_err_s  = 1'b0;
    case (op_r)
      OP_ADD, OP_SUB: begin
        reload_s    = ADD_RELOAD;
        unit_data_s = add_sum;
        unit_err_s  = add_err;
      end
      OP_MUL: begin
        reload_s    = MUL_RELOAD;
        unit_data_s = mul_res;
        unit_err_s  = mul_err;
      end
      OP_DIV: begin
        reload_s    = DIV_RELOAD;
        unit_data_s = div_res;
        unit_err_s  = div_err;
      end
      default: begin
        reload_s    = 16'd0;
        unit_data_s = 32'd0;
        unit_err_s  = 1'b0;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_any_s) begin
          state_nx_s = ST_ISSUE;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_ISSUE: state_nx_s = ST_WAIT;
      ST_WAIT: begin
        if (cnt_r == 16'd0) begin
          state_nx_s = ST_RESP;
        end else begin
          state_nx_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_RESP;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Latch the granted op, advance the pointer, drive operands and the start strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r      <= 2'b00;
      id_r      <= 3'd0;
      rr_ptr_r  <= 3'd0;
      fpu_a     <= 32'd0;
      fpu_b     <= 32'd0;
      add_valid <= 1'b0;
      mul_valid <= 1'b0;
      div_valid <= 1'b0;
    end else begin
      add_valid <= 1'b0;
      mul_valid <= 1'b0;
      div_valid <= 1'b0;
      if (accept_s) begin
        op_r     <= sel_op_s;
        id_r     <= grant_idx_s;
        rr_ptr_r <= (grant_idx_s == LAST_IDX) ? 3'd0 : grant_idx_s + 3'd1;
        fpu_a    <= sel_a_s;
        // SUB reuses the adder with the sign of B flipped
        fpu_b    <= (sel_op_s == OP_SUB) ? {~sel_b_s[31], sel_b_s[30:0]} : sel_b_s;
        case (sel_op_s)
          OP_ADD, OP_SUB: add_valid <= 1'b1;
          OP_MUL:         mul_valid <= 1'b1;
          OP_DIV:         div_valid <= 1'b1;
          default: begin
            add_valid <= 1'b0;
            mul_valid <= 1'b0;
            div_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  // Latency countdown: loaded in ISSUE so the sample edge lands LAT edges after the strobe edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= 16'd0;
    end else if (state_r == ST_ISSUE) begin
      cnt_r <= reload_s;
    end else if ((state_r == ST_WAIT) && (cnt_r != 16'd0)) begin
      cnt_r <= cnt_r - 16'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Capture the unit result and hold the response until it is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_id    <= 3'd0;
      resp_data  <= 32'd0;
      resp_err   <= 1'b0;
    end else if (sample_s) begin
      resp_valid <= 1'b1;
      resp_id    <= id_r;
      resp_data  <= unit_data_s;
      resp_err   <= unit_err_s;
    end else if (handshake_s) begin
      resp_valid <= 1'b0;
    end else begin
      resp_valid <= resp_valid;
    end
  end

`ifdef FPU_SCHED_STATS_EN
  // Count completed responses (wrapping) and errored responses (saturating)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ops  <= 32'd0;
      stat_errs <= 16'd0;
    end else if (handshake_s) begin
      stat_ops <= stat_ops + 32'd1;
      if (resp_err && (stat_errs != 16'hFFFF)) begin
        stat_errs <= stat_errs + 16'd1;
      end else begin
        stat_errs <= stat_errs;
      end
    end else begin
      stat_ops  <= stat_ops;
      stat_errs <= stat_errs;
    end
  end
`endif

endmodule

// File: tb/tb_fpu_op_scheduler.sv
// Testbench for fpu_op_scheduler: table-driven directed vectors, hand-written
// backpressure / reset sequences, and a randomized run checked cycle by cycle
// against a transaction-level reference model. The bench also plays the role
// of the three arithmetic units, presenting each result only on the exact
// cycle it is due.
module tb_fpu_op_scheduler;

  localparam int N   = 4;
  localparam int LAT = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [2*N-1:0]    req_op;
  logic [32*N-1:0]   req_a;
  logic [32*N-1:0]   req_b;
  logic              resp_valid;
  logic              resp_ready;
  logic [2:0]        resp_id;
  logic [31:0]       resp_data;
  logic              resp_err;
  logic [31:0]       fpu_a;
  logic [31:0]       fpu_b;
  logic              add_valid;
  logic              mul_valid;
  logic              div_valid;
  logic [31:0]       add_sum;
  logic [31:0]       mul_res;
  logic [31:0]       div_res;
  logic              add_err;
  logic              mul_err;
  logic              div_err;
`ifdef FPU_SCHED_STATS_EN
  logic [31:0]       stat_ops;
  logic [15:0]       stat_errs;
`endif

  logic [1:0]  op_drv [N];
  logic [31:0] a_drv  [N];
  logic [31:0] b_drv  [N];

  int n_tests = 0;
  int n_fail  = 0;
  int grants[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_op[2*g+1:2*g]   = op_drv[g];
    assign req_a[32*g+31:32*g] = a_drv[g];
    assign req_b[32*g+31:32*g] = b_drv[g];
  end

  fpu_op_scheduler #(
    .NUM_REQ(N), .ADD_LAT(LAT), .MUL_LAT(LAT), .DIV_LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_err(resp_err),
    .fpu_a(fpu_a), .fpu_b(fpu_b),
    .add_valid(add_valid), .mul_valid(mul_valid), .div_valid(div_valid),
    .add_sum(add_sum), .mul_res(mul_res), .div_res(div_res),
    .add_err(add_err), .mul_err(mul_err), .div_err(div_err)
`ifdef FPU_SCHED_STATS_EN
    , .stat_ops(stat_ops), .stat_errs(stat_errs)
`endif
  );

  // Behaviour of the arithmetic units: unit 0 adder, 1 multiplier, 2 divider.
  // Known IEEE cases give true results; other operands give distinct per-unit tokens.
  function automatic logic [32:0] unit_fn(input int unit, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] r;
    case (unit)
      0: begin
        if (a == 32'h3F800000 && b == 32'h40000000)      r = {1'b0, 32'h40400000};
        else if (a == 32'h40400000 && b == 32'hBF800000) r = {1'b0, 32'h40000000};
        else                                             r = {a[0] & b[0], a ^ {b[15:0], b[31:16]}};
      end
      1: begin
        if (a == 32'h40000000 && b == 32'h40400000) r = {1'b0, 32'h40C00000};
        else                                        r = {a[1] & b[1], a + b};
      end
      2: begin
        if (b == 32'h00000000) r = {1'b1, 32'h7F800000};
        else                   r = {a[2] ^ b[2], a - b};
      end
      default: r = 33'd0;
    endcase
    return r;
  endfunction

  function automatic int unit_of(input logic [1:0] op);
    return (op[1] == 1'b0) ? 0 : ((op == 2'b10) ? 1 : 2);
  endfunction

  function automatic logic [31:0] eff_b(input logic [1:0] op, input logic [31:0] b);
    return (op == 2'b01) ? {~b[31], b[30:0]} : b;
  endfunction

  // Unit models: result is valid only in the cycle ending at strobe edge + LAT
  logic [7:0]  add_cnt = 8'd0, mul_cnt = 8'd0, div_cnt = 8'd0;
  logic [32:0] add_hold = 33'd0, mul_hold = 33'd0, div_hold = 33'd0;

  always @(posedge clk) begin
    if (add_valid) begin
      add_cnt  <= 8'(LAT);
      add_hold <= unit_fn(0, fpu_a, fpu_b);
    end else if (add_cnt != 8'd0) add_cnt <= add_cnt - 8'd1;
    if (mul_valid) begin
      mul_cnt  <= 8'(LAT);
      mul_hold <= unit_fn(1, fpu_a, fpu_b);
    end else if (mul_cnt != 8'd0) mul_cnt <= mul_cnt - 8'd1;
    if (div_valid) begin
      div_cnt  <= 8'(LAT);
      div_hold <= unit_fn(2, fpu_a, fpu_b);
    end else if (div_cnt != 8'd0) div_cnt <= div_cnt - 8'd1;
  end

  assign add_sum = (add_cnt == 8'd1) ? add_hold[31:0] : 32'hDEADBEEF;
  assign add_err = (add_cnt == 8'd1) ? add_hold[32]   : ~add_hold[32];
  assign mul_res = (mul_cnt == 8'd1) ? mul_hold[31:0] : 32'hDEADBEEF;
  assign mul_err = (mul_cnt == 8'd1) ? mul_hold[32]   : ~mul_hold[32];
  assign div_res = (div_cnt == 8'd1) ? div_hold[31:0] : 32'hDEADBEEF;
  assign div_err = (div_cnt == 8'd1) ? div_hold[32]   : ~div_hold[32];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset resp", {resp_valid, resp_id, resp_err, resp_data}, 64'd0);
    chk("reset fpu", {fpu_a, fpu_b}, 64'd0);
    chk("reset ctl", {req_ready, add_valid, mul_valid, div_valid}, 64'd0);
`ifdef FPU_SCHED_STATS_EN
    chk("reset stats", {stat_ops, stat_errs}, 64'd0);
`endif
    rst = 1'b0;
  endtask

  typedef struct {
    int          id;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  strobe;   // {add, mul, div}
    logic [31:0] fb;
    logic [31:0] data;
    logic        err;
  } vec_t;

  vec_t vecs [4];

  // Single isolated op: accept, strobe/operands, latency, tagged response
  task automatic run_vec(input vec_t v);
    int n;
    @(posedge clk); #1;
    op_drv[v.id] = v.op; a_drv[v.id] = v.a; b_drv[v.id] = v.b;
    req_valid = 4'(1 << v.id);
    resp_ready = 1'b1;
    @(negedge clk);
    chk("vec ready", req_ready, 64'(1 << v.id));
    @(posedge clk); #1;
    req_valid = '0;
    a_drv[v.id] = $urandom;
    b_drv[v.id] = $urandom;
    @(negedge clk);
    chk("vec strobe", {add_valid, mul_valid, div_valid}, v.strobe);
    chk("vec fpu", {fpu_a, fpu_b}, {v.a, v.fb});
    n = 1;
    while (!resp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("vec latency", n, LAT + 2);
    chk("vec resp", {resp_err, resp_id, resp_data}, {v.err, 3'(v.id), v.data});
    chk("vec ready busy", req_ready, 64'd0);
    @(negedge clk);
    chk("vec resp drop", resp_valid, 64'd0);
  endtask

  // Randomized traffic against a transaction-level model.
  // mode 0: random requests/drops/backpressure; mode 1: all requesters always valid.
  task automatic run_model(input int cycles, input int mode);
    logic [N-1:0] pend;
    int rr, t, acc, g, u, hs, errs, obs;
    bit busy;
    logic [31:0] xa, xb;
    logic [32:0] xres;
    logic [2:0] xid;
    pend = '0; rr = 0; t = 0; acc = -1; busy = 1'b0; hs = 0; errs = 0; u = 0;
    xa = 32'd0; xb = 32'd0; xres = 33'd0; xid = 3'd0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      if (acc >= 0) begin
        pend[acc] = 1'b0;
        acc = -1;
      end
      for (int i = 0; i < N; i++) begin
        if (!pend[i]) begin
          op_drv[i] = 2'($urandom_range(0, 3));
          a_drv[i]  = $urandom;
          b_drv[i]  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
          if (mode == 1 || $urandom_range(0, 3) == 0) pend[i] = 1'b1;
        end else if (mode == 0 && $urandom_range(0, 24) == 0) begin
          pend[i] = 1'b0;
        end
      end
      req_valid  = pend;
      resp_ready = (mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
      @(negedge clk);
      for (int i = 0; i < N; i++) if (req_ready[i]) obs = i;
      if (req_ready != '0) grants.push_back(obs);
      if (!busy) begin
        g = -1;
        for (int k = 0; k < N; k++) if (g < 0 && pend[(rr + k) % N]) g = (rr + k) % N;
        chk("rand ready idle", req_ready, (g >= 0) ? 64'(1 << g) : 64'd0);
        chk("rand resp idle", resp_valid, 64'd0);
        chk("rand strobe idle", {add_valid, mul_valid, div_valid}, 64'd0);
        if (g >= 0) begin
          busy = 1'b1; t = 0; rr = (g + 1) % N; acc = g;
          u    = unit_of(op_drv[g]);
          xa   = a_drv[g];
          xb   = eff_b(op_drv[g], b_drv[g]);
          xres = unit_fn(u, xa, xb);
          xid  = 3'(g);
        end
      end else begin
        t++;
        chk("rand ready busy", req_ready, 64'd0);
        chk("rand strobe", {add_valid, mul_valid, div_valid}, (t == 1) ? 64'(3'b100 >> u) : 64'd0);
        if (t == 1) chk("rand fpu", {fpu_a, fpu_b}, {xa, xb});
        if (t < LAT + 2) begin
          chk("rand resp early", resp_valid, 64'd0);
        end else begin
          chk("rand resp valid", resp_valid, 64'd1);
          chk("rand resp", {resp_err, resp_id, resp_data}, {xres[32], xid, xres[31:0]});
          if (resp_ready) begin
            busy = 1'b0;
            hs++;
            if (xres[32]) errs++;
          end
        end
      end
    end
    @(negedge clk);
`ifdef FPU_SCHED_STATS_EN
    chk("stat ops", stat_ops, 64'(hs));
    chk("stat errs", stat_errs, 64'(errs));
`endif
  endtask

  initial begin
    int n;
    int exp_order [5];
    rst = 1'b1;
    req_valid = '0;
    resp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      op_drv[i] = 2'b00; a_drv[i] = 32'd0; b_drv[i] = 32'd0;
    end
    vecs[0] = '{0, 2'b00, 32'h3F800000, 32'h40000000, 3'b100, 32'h40000000, 32'h40400000, 1'b0};
    vecs[1] = '{1, 2'b01, 32'h40400000, 32'h3F800000, 3'b100, 32'hBF800000, 32'h40000000, 1'b0};
    vecs[2] = '{2, 2'b10, 32'h40000000, 32'h40400000, 3'b010, 32'h40400000, 32'h40C00000, 1'b0};
    vecs[3] = '{3, 2'b11, 32'h3F800000, 32'h00000000, 3'b001, 32'h00000000, 32'h7F800000, 1'b1};
    exp_order = '{0, 1, 2, 3, 0};

    do_reset();
    for (int v = 0; v < 4; v++) run_vec(vecs[v]);

    // Backpressure: response held 5 cycles, others waiting, grant right after handshake
    do_reset();
    @(posedge clk); #1;
    op_drv[2] = 2'b10; a_drv[2] = 32'h40000000; b_drv[2] = 32'h40400000;
    req_valid = 4'b0100;
    resp_ready = 1'b0;
    @(negedge clk);
    chk("bp ready", req_ready, 64'h4);
    @(posedge clk); #1;
    op_drv[0] = 2'b00; a_drv[0] = 32'h11111111; b_drv[0] = 32'h22222222;
    op_drv[3] = 2'b00; a_drv[3] = 32'h33333333; b_drv[3] = 32'h44444444;
    req_valid = 4'b1001;
    n = 0;
    while (!resp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("bp latency", n, LAT + 2);
    for (int k = 0; k < 5; k++) begin
      chk("bp hold", {resp_valid, resp_err, resp_id, resp_data}, {1'b1, 1'b0, 3'd2, 32'h40C00000});
      chk("bp ready busy", req_ready, 64'd0);
      if (k < 4) @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp resp drop", resp_valid, 64'd0);
    chk("bp next grant", req_ready, 64'h8);

    // Reset during WAIT: outputs clear at once, late result ignored, pointer back to 0
    do_reset();
    @(posedge clk); #1;
    op_drv[2] = 2'b00; a_drv[2] = 32'h3F800000; b_drv[2] = 32'h40000000;
    req_valid = 4'b0100;
    @(negedge clk);
    chk("rw ready", req_ready, 64'h4);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rw async resp", {resp_valid, resp_id, resp_err, resp_data}, 64'd0);
    chk("rw async fpu", {fpu_a, fpu_b}, 64'd0);
    chk("rw async ctl", {req_ready, add_valid, mul_valid, div_valid}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("rw no resp", {resp_valid, add_valid, mul_valid, div_valid}, 64'd0);
    end
    @(posedge clk); #1;
    op_drv[1] = 2'b10; op_drv[3] = 2'b10;
    req_valid = 4'b1010;
    @(negedge clk);
    chk("rw grant from 0", req_ready, 64'h2);

    // All requesters held high: grant order 0,1,2,3,0
    do_reset();
    grants.delete();
    run_model(100, 1);
    for (int i = 0; i < 5; i++) begin
      chk("grant order", (grants.size() > i) ? grants[i] : -1, exp_order[i]);
    end

    // Randomized traffic
    do_reset();
    run_model(1500, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
